// File: rtl/imm_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// imm_encoder_loader_if
// Bundles the loader's two bus-facing channels:
//   request channel : req_valid/req_ready handshake carrying immsrc, the base
//                     instruction and the signed immediate to encode.
//   memory channel  : we/waddr/wdata write request closed by wr_ack.
// slave  modport : the loader itself (accepts requests, issues writes).
// master modport : the host/debug side plus the instruction memory.
// ---------------------------------------------------------------------------
interface imm_encoder_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_immsrc;
    logic [31:0]           req_base;
    logic [31:0]           req_imm;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           wdata;
    logic                  wr_ack;

    modport slave (
        input  req_valid, req_immsrc, req_base, req_imm, wr_ack,
        output req_ready, we, waddr, wdata
    );

    modport master (
        output req_valid, req_immsrc, req_base, req_imm, wr_ack,
        input  req_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imm_encoder_loader.sv
// ---------------------------------------------------------------------------
// imm_encoder_loader
// Loads instruction memory from a host/debug port. Each request supplies a
// base instruction, a signed immediate and an immsrc format (I/S/B/J). The
// immediate is range/alignment checked, scattered into the format's bit
// positions and written to an auto-incrementing word address.
// Ports:
//   clk      - clock, rising-edge
//   reset    - asynchronous reset, active-low
//   clear    - synchronous clear: abort write, reload address, clear flags
//   bus      - request + memory write channels (slave modport)
//   err      - sticky error flag (first error is kept)
//   err_code - 00 none, 01 range, 10 misaligned, 11 full
//   full     - all 2^ADDR_WIDTH words have been written
//   count    - words written since reset/clear
// ---------------------------------------------------------------------------
module imm_encoder_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    imm_encoder_loader_if.slave   bus,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_FULL  = 2'b11;

    typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;

    state_t                state_q,    state_d;
    logic [1:0]            immsrc_q,   immsrc_d;
    logic [31:0]           base_q,     base_d;
    logic [31:0]           imm_q,      imm_d;
    logic [31:0]           wdata_q,    wdata_d;
    logic [ADDR_WIDTH-1:0] waddr_q,    waddr_d;
    logic                  err_q,      err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  full_q,     full_d;
    logic [ADDR_WIDTH:0]   count_q,    count_d;

    logic [31:0] enc_word;
    logic        range_ok;
    logic [1:0]  fault_code;

    // Scatter the immediate into the format's fields and check that it fits:
    // the bits above the encodable field must be a pure sign extension.
    always_comb begin
        enc_word = base_q;
        range_ok = 1'b0;
        case (immsrc_q)
            FMT_I: begin
                enc_word[31:20] = imm_q[11:0];
                range_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
            end
            FMT_S: begin
                enc_word[31:25] = imm_q[11:5];
                enc_word[11:7]  = imm_q[4:0];
                range_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
            end
            FMT_B: begin
                enc_word[31]    = imm_q[12];
                enc_word[30:25] = imm_q[10:5];
                enc_word[11:8]  = imm_q[4:1];
                enc_word[7]     = imm_q[11];
                range_ok = (&imm_q[31:12]) | ~(|imm_q[31:12]);
            end
            default: begin
                enc_word[31]    = imm_q[20];
                enc_word[30:21] = imm_q[10:1];
                enc_word[20]    = imm_q[11];
                enc_word[19:12] = imm_q[19:12];
                range_ok = (&imm_q[31:20]) | ~(|imm_q[31:20]);
            end
        endcase

        // Priority: full, then misalignment (B/J only), then range.
        if (full_q)
            fault_code = ERR_FULL;
        else if (immsrc_q[1] && imm_q[0])
            fault_code = ERR_ALIGN;
        else if (!range_ok)
            fault_code = ERR_RANGE;
        else
            fault_code = ERR_NONE;
    end

    always_comb begin
        state_d    = state_q;
        immsrc_d   = immsrc_q;
        base_d     = base_q;
        imm_d      = imm_q;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        full_d     = full_q;
        count_d    = count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    immsrc_d = bus.req_immsrc;
                    base_d   = bus.req_base;
                    imm_d    = bus.req_imm;
                    state_d  = ENCODE;
                end
            end
            ENCODE: begin
                if (fault_code != ERR_NONE) begin
                    // Only the first error is latched until clear/reset.
                    if (!err_q) begin
                        err_d      = 1'b1;
                        err_code_d = fault_code;
                    end
                    state_d = IDLE;
                end else begin
                    wdata_d = enc_word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.wr_ack) begin
                    waddr_d = waddr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    full_d  = ((count_q + 1'b1) == CAPACITY);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides everything, including a same-cycle handshake.
        if (clear) begin
            state_d    = IDLE;
            waddr_d    = BASE;
            count_d    = '0;
            full_d     = 1'b0;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            immsrc_q   <= 2'b00;
            base_q     <= '0;
            imm_q      <= '0;
            wdata_q    <= '0;
            waddr_q    <= BASE;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            full_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            immsrc_q   <= immsrc_d;
            base_q     <= base_d;
            imm_q      <= imm_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            full_q     <= full_d;
            count_q    <= count_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.we        = (state_q == WRITE);
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign full          = full_q;
    assign count         = count_q;
endmodule

// File: tb/tb_imm_encoder_loader.sv
module tb_imm_encoder_loader;
    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    imm_encoder_loader_if #(.ADDR_WIDTH(AW)) bus ();
    logic          err;
    logic [1:0]    err_code;
    logic          full;
    logic [AW:0]   count;

    imm_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus),
        .err      (err),
        .err_code (err_code),
        .full     (full),
        .count    (count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int         m_waddr;
    int         m_count;
    bit         m_full;
    bit         m_err;
    logic [1:0] m_code;

    task automatic model_reset();
        m_waddr = 0; m_count = 0; m_full = 0; m_err = 0; m_code = 2'b00;
    endtask

    // Immediate extender (decode direction): recovers the immediate from a word.
    function automatic logic [31:0] ext_imm(input logic [31:0] w, input logic [1:0] s);
        case (s)
            2'd0:    return {{20{w[31]}}, w[31:20]};
            2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2:    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            default: return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    // Bits of the instruction that are not immediate fields.
    function automatic logic [31:0] pass_mask(input logic [1:0] s);
        case (s)
            2'd0:    return 32'h000F_FFFF;
            2'd1:    return 32'h01FF_F07F;
            2'd2:    return 32'h01FF_F07F;
            default: return 32'h0000_0FFF;
        endcase
    endfunction

    function automatic logic [1:0] model_fault(input logic [1:0] s, input logic [31:0] imm);
        int v;
        int lim;
        v = $signed(imm);
        case (s)
            2'd0, 2'd1: lim = 2048;
            2'd2:       lim = 4096;
            default:    lim = 1 << 20;
        endcase
        if (m_full) return 2'b11;
        if (s[1] && imm[0]) return 2'b10;
        if (v < -lim || v > lim - 1) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from IDLE and checks its whole life against the model.
    task automatic run_req(input logic [1:0] src, input logic [31:0] base, input logic [31:0] imm,
                           input int ack_delay, input bit chk_wdata, input logic [31:0] exp_wdata);
        logic [1:0] fault;
        int exp_addr;
        fault    = model_fault(src, imm);
        exp_addr = m_waddr;
        bus.req_valid  = 1'b1;
        bus.req_immsrc = src;
        bus.req_base   = base;
        bus.req_imm    = imm;
        bus.wr_ack     = (ack_delay == 0);
        step();
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.we !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL encode_cycle: got we=%b ready=%b expected we=0 ready=0", bus.we, bus.req_ready);
        end
        step();
        if (fault != 2'b00) begin
            if (!m_err) begin m_err = 1; m_code = fault; end
            n_cmp++;
            if (bus.we !== 1'b0) begin
                n_fail++;
                $display("FAIL err_no_write: got we=%b expected 0", bus.we);
            end
            n_cmp++;
            if (err !== m_err || err_code !== m_code || bus.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL err_flags: got err=%b code=%b ready=%b expected err=%b code=%b ready=1",
                         err, err_code, bus.req_ready, m_err, m_code);
            end
            $display("req src=%0d base=%h imm=%h -> rejected fault=%b err_code=%b", src, base, imm, fault, err_code);
        end else begin
            n_cmp++;
            if (bus.we !== 1'b1 || bus.waddr !== AW'(exp_addr)) begin
                n_fail++;
                $display("FAIL write_start: got we=%b waddr=%0d expected we=1 waddr=%0d", bus.we, bus.waddr, exp_addr);
            end
            if (chk_wdata) begin
                n_cmp++;
                if (bus.wdata !== exp_wdata) begin
                    n_fail++;
                    $display("FAIL wdata: got %h expected %h", bus.wdata, exp_wdata);
                end
            end
            for (int i = 0; i <= ack_delay; i++) begin
                n_cmp++;
                if (bus.we !== 1'b1 || bus.waddr !== AW'(exp_addr) || ext_imm(bus.wdata, src) !== imm ||
                    (bus.wdata & pass_mask(src)) !== (base & pass_mask(src))) begin
                    n_fail++;
                    $display("FAIL write_hold: cycle %0d got we=%b waddr=%0d wdata=%h expected we=1 waddr=%0d imm=%h base=%h",
                             i, bus.we, bus.waddr, bus.wdata, exp_addr, imm, base);
                end
                if (i < ack_delay) step();
            end
            $display("req src=%0d base=%h imm=%h -> write waddr=%0d wdata=%h ack_delay=%0d",
                     src, base, imm, bus.waddr, bus.wdata, ack_delay);
            bus.wr_ack = 1'b1;
            step();
            m_waddr = (m_waddr + 1) % CAP;
            m_count = m_count + 1;
            m_full  = (m_count == CAP);
            n_cmp++;
            if (bus.we !== 1'b0 || bus.req_ready !== 1'b1 || bus.waddr !== AW'(m_waddr) ||
                count !== (AW+1)'(m_count) || full !== m_full || err !== m_err) begin
                n_fail++;
                $display("FAIL write_done: got we=%b ready=%b waddr=%0d count=%0d full=%b err=%b expected 0 1 %0d %0d %b %b",
                         bus.we, bus.req_ready, bus.waddr, count, full, err, m_waddr, m_count, m_full, m_err);
            end
        end
        bus.wr_ack = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.we !== 1'b0 || bus.req_ready !== 1'b1 || bus.waddr !== '0 || count !== '0 ||
            full !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_state: got we=%b ready=%b waddr=%0d count=%0d full=%b err=%b code=%b expected 0 1 0 0 0 0 00",
                     bus.we, bus.req_ready, bus.waddr, count, full, err, err_code);
        end
        $display("clear -> waddr=%0d count=%0d", bus.waddr, count);
    endtask

    function automatic logic [31:0] legal_imm(input logic [1:0] s);
        logic [31:0] r;
        r = $urandom;
        case (s)
            2'd0, 2'd1: return {{20{r[11]}}, r[11:0]};
            2'd2:       return {{19{r[12]}}, r[12:1], 1'b0};
            default:    return {{11{r[20]}}, r[20:1], 1'b0};
        endcase
    endfunction

    task automatic test_reset();
        step(); step();
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.we !== 1'b0 || bus.waddr !== '0 || bus.wdata !== '0 ||
            err !== 1'b0 || err_code !== 2'b00 || full !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%b we=%b waddr=%0d wdata=%h err=%b code=%b full=%b count=%0d",
                     bus.req_ready, bus.we, bus.waddr, bus.wdata, err, err_code, full, count);
        end
        reset = 1'b1;
        model_reset();
        step();
        $display("reset released");
    endtask

    task automatic test_i_type();
        run_req(2'b00, 32'h0000_0093, 32'hFFFF_FFFF, 0, 1, 32'hFFF0_0093);
    endtask

    task automatic test_back_to_back();
        do_clear();
        run_req(2'b01, 32'h0020_2023, 32'h0000_0008, 0, 1, 32'h0020_2423);
        run_req(2'b10, 32'h0000_0063, 32'hFFFF_FFFC, 0, 1, 32'hFE00_0EE3);
        n_cmp++;
        if (bus.waddr !== 2'd2) begin
            n_fail++;
            $display("FAIL b2b_waddr: got %0d expected 2", bus.waddr);
        end
    endtask

    task automatic test_delayed_ack();
        run_req(2'b11, 32'h0000_00EF, 32'h0000_0800, 3, 1, 32'h0010_00EF);
    endtask

    task automatic test_errors();
        do_clear();
        run_req(2'b00, 32'h0000_0013, 32'h0000_0800, 0, 0, 32'h0);
        run_req(2'b10, 32'h0000_0063, 32'h0000_0003, 0, 0, 32'h0);
        n_cmp++;
        if (err_code !== 2'b01) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 01", err_code);
        end
        run_req(2'b00, 32'h0000_0013, 32'h0000_0010, 0, 0, 32'h0);
        do_clear();
        run_req(2'b10, 32'h0000_0063, 32'h0000_0003, 0, 0, 32'h0);
        n_cmp++;
        if (err_code !== 2'b10) begin
            n_fail++;
            $display("FAIL err_misaligned: got %b expected 10", err_code);
        end
    endtask

    task automatic test_full_wrap();
        logic [1:0] s;
        do_clear();
        for (int i = 0; i < CAP; i++) begin
            s = 2'($urandom_range(0, 3));
            run_req(s, $urandom, legal_imm(s), int'($urandom_range(0, 1)), 0, 32'h0);
        end
        n_cmp++;
        if (bus.waddr !== '0 || count !== 3'd4 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wrap: got waddr=%0d count=%0d full=%b expected 0 4 1", bus.waddr, count, full);
        end
        run_req(2'b00, 32'h0000_0013, 32'h0000_0001, 0, 0, 32'h0);
        n_cmp++;
        if (err_code !== 2'b11) begin
            n_fail++;
            $display("FAIL full_err: got %b expected 11", err_code);
        end
        do_clear();
    endtask

    task automatic test_clear_discard();
        bus.req_valid  = 1'b1;
        bus.req_immsrc = 2'b00;
        bus.req_base   = 32'h0000_0013;
        bus.req_imm    = 32'h0000_0005;
        bus.wr_ack     = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus.req_valid = 1'b0;
        model_reset();
        step();
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.we !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL clear_discard: got ready=%b we=%b count=%0d expected 1 0 0", bus.req_ready, bus.we, count);
        end
        bus.wr_ack = 1'b0;
        $display("clear with concurrent request -> ready=%b we=%b", bus.req_ready, bus.we);
    endtask

    task automatic test_clear_mid_write();
        run_req(2'b01, 32'h0000_0023, 32'h0000_0004, 0, 0, 32'h0);
        bus.req_valid  = 1'b1;
        bus.req_immsrc = 2'b00;
        bus.req_imm    = 32'h0000_0007;
        step();
        bus.req_valid = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.we !== 1'b0 || bus.waddr !== '0 || count !== '0) begin
            n_fail++;
            $display("FAIL clear_mid_write: got we=%b waddr=%0d count=%0d expected 0 0 0", bus.we, bus.waddr, count);
        end
        $display("clear during write -> we=%b waddr=%0d", bus.we, bus.waddr);
    endtask

    task automatic test_reset_mid_write();
        run_req(2'b00, 32'h0000_0013, 32'h0000_0001, 0, 0, 32'h0);
        bus.req_valid  = 1'b1;
        bus.req_immsrc = 2'b00;
        bus.req_imm    = 32'h0000_0123;
        step();
        bus.req_valid = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.we !== 1'b0 || bus.req_ready !== 1'b1 || bus.waddr !== '0 || bus.wdata !== '0 ||
            count !== '0 || err !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got we=%b ready=%b waddr=%0d wdata=%h count=%0d err=%b full=%b",
                     bus.we, bus.req_ready, bus.waddr, bus.wdata, count, err, full);
        end
        step();
        reset = 1'b1;
        model_reset();
        step();
        $display("reset during write -> we=%b waddr=%0d", bus.we, bus.waddr);
        run_req(2'b01, 32'h0000_0023, 32'hFFFF_F800, 0, 0, 32'h0);
    endtask

    task automatic test_random();
        logic [1:0]  s;
        logic [31:0] imm;
        int          kind;
        for (int n = 0; n < 40; n++) begin
            if (m_full && $urandom_range(0, 1) == 1) do_clear();
            s    = 2'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      imm = $urandom;
            else if (kind == 1) imm = legal_imm(s) | 32'h1;
            else                imm = legal_imm(s);
            run_req(s, $urandom, imm, int'($urandom_range(0, 2)), 0, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_immsrc = 2'b00;
        bus.req_base   = '0;
        bus.req_imm    = '0;
        bus.wr_ack     = 1'b0;
        model_reset();
        test_reset();
        test_i_type();
        test_back_to_back();
        test_delayed_ack();
        test_errors();
        test_full_wrap();
        test_clear_discard();
        test_clear_mid_write();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
